// File: rtl/audio_cic_interp.sv
// audio_cic_interp
//   CIC interpolator for audio. A low-rate sample stream is held in a
//   1-entry buffer and consumed once every RATE output strobes. The comb
//   cascade runs at the low rate, the integrator cascade at the high rate.
//   The result is scaled so the DC gain is exactly 1.
//
// Ports
//   clk        single clock, rising edge
//   reset_n    asynchronous active-low reset
//   in_valid   snd_in carries a valid low-rate sample
//   in_ready   block accepts snd_in this cycle
//   snd_in     low-rate signed sample (IW bits)
//   out_cen    output-rate strobe; one high-rate step per pulse
//   snd_out    high-rate signed sample (IW bits)
//   out_valid  one-cycle pulse, the cycle after out_cen
//   underrun   one-cycle pulse, the buffer was empty when a sample was consumed
module audio_cic_interp #(
  parameter int IW     = 16,
  parameter int STAGES = 3,
  parameter int RATE   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [IW-1:0] snd_in,
  input  logic                 out_cen,
  output logic signed [IW-1:0] snd_out,
  output logic                 out_valid,
  output logic                 underrun
);

  localparam int LOG2R = $clog2(RATE);
  localparam int CALCW = IW + STAGES * LOG2R;
  localparam int SHIFT = (STAGES - 1) * LOG2R;

  logic signed [CALCW-1:0] dly   [STAGES];
  logic signed [CALCW-1:0] integ [STAGES];
  logic signed [CALCW-1:0] cin   [STAGES];
  logic signed [CALCW-1:0] inew  [STAGES];

  logic signed [IW-1:0]    buf_data;
  logic                    buf_full;
  logic signed [IW-1:0]    hold;
  logic [LOG2R-1:0]        phase;

  logic                    consume;
  logic                    xfer;
  logic signed [CALCW-1:0] x;
  logic signed [CALCW-1:0] comb_acc;
  logic signed [CALCW-1:0] u;
  logic signed [CALCW-1:0] int_acc;
  logic signed [IW-1:0]    out_next;

  assign consume  = out_cen && (phase == '0);
  assign in_ready = !buf_full || consume;
  assign xfer     = in_valid && in_ready;

  // Comb and integrator cascades are built with a running accumulator so
  // that no array feeds back into itself inside the combinational block.
  always_comb begin
    x = buf_full ? {{(CALCW-IW){buf_data[IW-1]}}, buf_data}
                 : {{(CALCW-IW){hold[IW-1]}}, hold};
    comb_acc = x;
    for (int unsigned k = 0; k < STAGES; k++) begin
      cin[k]   = comb_acc;
      comb_acc = comb_acc - dly[k];
    end
    u = (phase == '0) ? comb_acc : '0;
    int_acc = u;
    for (int unsigned k = 0; k < STAGES; k++) begin
      int_acc = integ[k] + int_acc;
      inew[k] = int_acc;
    end
    out_next = IW'(inew[STAGES-1] >>> SHIFT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        dly[k]   <= '0;
        integ[k] <= '0;
      end
      buf_data  <= '0;
      buf_full  <= 1'b0;
      hold      <= '0;
      phase     <= '0;
      snd_out   <= '0;
      out_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      out_valid <= out_cen;
      underrun  <= consume && !buf_full;

      // A same-cycle transfer refills the buffer after the old entry is
      // consumed; an empty buffer is never bypassed.
      if (xfer) begin
        buf_data <= snd_in;
        buf_full <= 1'b1;
      end else if (consume) begin
        buf_full <= 1'b0;
      end

      if (consume) begin
        if (buf_full) hold <= buf_data;
        for (int unsigned k = 0; k < STAGES; k++) dly[k] <= cin[k];
      end

      if (out_cen) begin
        for (int unsigned k = 0; k < STAGES; k++) integ[k] <= inew[k];
        snd_out <= out_next;
        phase   <= phase + 1'b1;
      end
    end
  end

endmodule

// File: doc/audio_cic_interp.md
AUDIO_CIC_INTERP -- requirements
Module: audio_cic_interp

Interface
REQ-001 SHALL provide parameter IW, default 16, input/output sample width (signed two's complement).
REQ-002 SHALL provide parameter STAGES, default 3, number of comb stages and of integrator stages (range 1..6).
REQ-003 SHALL provide parameter RATE, default 4, interpolation ratio, power of two only (2..64); LOG2R = log2(RATE).
REQ-004 SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL provide port reset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL provide port in_valid  input  1  snd_in holds a valid low-rate sample.
REQ-007 SHALL provide port in_ready  output  1  block accepts snd_in this cycle.
REQ-008 SHALL provide port snd_in  input  IW  low-rate signed sample.
REQ-009 SHALL provide port out_cen  input  1  output-rate strobe, one high-rate sample step per pulse.
REQ-010 SHALL provide port snd_out  output  IW  high-rate signed sample.
REQ-011 SHALL provide port out_valid  output  1  one-cycle pulse, snd_out updated.
REQ-012 SHALL provide port underrun  output  1  one-cycle pulse, no buffered sample at consume time.

Function
REQ-013 SHALL hold internal width CALCW = IW + STAGES*LOG2R for all comb/integrator registers, wrapping modulo 2^CALCW.
REQ-014 SHALL keep a 1-entry input buffer; handshake transfers when in_valid && in_ready.
REQ-015 SHALL drive in_ready = !buf_full || consume, where consume = out_cen && phase==0.
REQ-016 SHALL, on simultaneous transfer and consume with full buffer, consume old entry and store new entry (buffer stays full).
REQ-017 SHALL keep phase counter 0..RATE-1, advancing by 1 on each out_cen, wrapping RATE-1 -> 0; unchanged without out_cen.
REQ-018 SHALL, on consume, take comb input x = buffer (sign-extended to CALCW) if full, else last consumed sample (hold), and clear buffer.
REQ-019 SHALL, on consume with empty buffer, pulse underrun for that cycle; a same-cycle transfer fills buffer, no bypass.
REQ-020 SHALL, on consume only, evaluate comb cascade combinationally: c0 = x - d0, ck = c(k-1) - dk; each delay dk <= stage input.
REQ-021 SHALL form upsampled value u = c(STAGES-1) when phase==0, else 0 (zero-stuffing).
REQ-022 SHALL, on every out_cen, update integrators as combinational cascade: i0 <= i0 + u, ik <= ik + new i(k-1).
REQ-023 SHALL, on every out_cen, register snd_out <= low IW bits of (new i(STAGES-1) arithmetic-shifted right by (STAGES-1)*LOG2R), floor rounding.
REQ-024 SHALL assert out_valid in the cycle after each out_cen (one-cycle latency); out_cen on consecutive cycles is legal.
REQ-025 SHALL leave all state unchanged in cycles without out_cen, except the input buffer transfer.
REQ-026 SHALL produce DC gain of exactly 1 at snd_out for constant input after STAGES*RATE out_cen pulses.

Reset
REQ-027 SHALL, while reset_n low, clear all comb delays, integrators, hold sample, buffer flag, phase, snd_out, out_valid, underrun to 0, immediately and asynchronously.
REQ-028 SHALL drive in_ready high while reset_n low; transfers during reset are discarded.
REQ-029 SHALL, on reset mid-stream, discard the buffered sample; first out_cen after release is phase 0.

Verification (IW=16, STAGES=2, RATE=4, out_cen every cycle unless stated)
REQ-030 SHALL pass step test: 4000 presented continuously from reset release -> snd_out 1000, 2000, 3000, 4000, then 4000 steady; underrun never pulses.
REQ-031 SHALL pass impulse test: one sample 8000 then zeros -> snd_out 2000, 4000, 6000, 8000, 6000, 4000, 2000, 0, then 0.
REQ-032 SHALL pass underrun test: buffer empty at phase 0 after last sample 4000 -> underrun pulses once, snd_out stays 4000.
REQ-033 SHALL pass backpressure test: buffer full, in_valid held, out_cen every 3rd cycle -> in_ready high only in consume cycles, exactly one transfer per 4 out_cen.
REQ-034 SHALL pass negative full-scale test: constant -32768 -> steady snd_out -32768, no wrap glitch.
REQ-035 SHALL pass async reset test: reset_n low between clock edges mid-ramp -> snd_out, out_valid, phase 0 before next edge; restart reproduces REQ-030 sequence.
